palette_color_pipeline: RTL and testbench

// - Next-generation pixel colouriser for the Tetris VGA path. Maps each pixel's block index to RGB through a

---
 rtl/palette_color_pipeline.sv | 174 +++++++++++++++++
 tb/tb_palette_color_pipeline.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/palette_color_pipeline.sv
// Two-stage pixel colouriser: palette lookup, ball, background gradient and line-clear flash.
// Optional feature macro: GHOST_SHADE_EN (half-intensity ghost piece pixels).
module palette_color_pipeline #(
  parameter int          CW           = 8,
  parameter int          IDX_W        = 3,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [7:0]  BG_R         = 8'h1f,
  parameter logic [7:0]  BG_B         = 8'h7f
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_valid_in,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              play_area,
  input  logic              is_ball,
  input  logic [IDX_W-1:0]  block_type,
  input  logic              flash_row,
  input  logic              ghost,
  input  logic              pal_wr_en,
  input  logic [IDX_W-1:0]  pal_wr_idx,
  input  logic [3*CW-1:0]   pal_wr_rgb,
  output logic              pix_valid_out,
  output logic [CW-1:0]     VGA_R,
  output logic [CW-1:0]     VGA_G,
  output logic [CW-1:0]     VGA_B
);

  localparam int DEPTH = 2**IDX_W;
  localparam int FW    = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CW-1:0] FULL = '1;

  // Colour constants are written on an 8-bit scale; keep the top CW bits.
  function automatic logic [CW-1:0] scale8(input logic [7:0] v);
    return v[7 -: CW];
  endfunction

  function automatic logic [3*CW-1:0] default_entry(input int idx);
    logic [23:0] rgb8;
    case (idx)
      1:       rgb8 = 24'h00ffff;
      2:       rgb8 = 24'h0000ff;
      3:       rgb8 = 24'hffa500;
      4:       rgb8 = 24'hffff00;
      5:       rgb8 = 24'h008000;
      6:       rgb8 = 24'hff0000;
      7:       rgb8 = 24'hff00ff;
      default: rgb8 = 24'h000000;
    endcase
    return {scale8(rgb8[23:16]), scale8(rgb8[15:8]), scale8(rgb8[7:0])};
  endfunction

  logic [3*CW-1:0] palette [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) palette[i] <= default_entry(i);
    end else if (pal_wr_en) begin
      palette[pal_wr_idx] <= pal_wr_rgb;
    end
  end

  logic [FW-1:0] flash_cnt;
  logic          flash_phase;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (flash_cnt == FW'(FLASH_FRAMES - 1)) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // Stage 1: capture control, coarse X and the palette entry (pre-write value on a same-cycle write).
  logic            s1_valid, s1_play, s1_ball, s1_flash;
  logic [6:0]      s1_xcoarse;
  logic [3*CW-1:0] s1_pal;
`ifdef GHOST_SHADE_EN
  logic            s1_ghost;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_play    <= 1'b0;
      s1_ball    <= 1'b0;
      s1_flash   <= 1'b0;
      s1_xcoarse <= '0;
      s1_pal     <= '0;
`ifdef GHOST_SHADE_EN
      s1_ghost   <= 1'b0;
`endif
    end else begin
      s1_valid   <= pix_valid_in;
      s1_play    <= play_area;
      s1_ball    <= is_ball;
      s1_flash   <= flash_row;
      s1_xcoarse <= DrawX[9:3];
      s1_pal     <= palette[block_type];
`ifdef GHOST_SHADE_EN
      s1_ghost   <= ghost;
`endif
    end
  end

  logic [CW-1:0] pal_r, pal_g, pal_b, bg_b, x_cw;
  logic [CW-1:0] nxt_r, nxt_g, nxt_b;

  assign pal_r = s1_pal[3*CW-1:2*CW];
  assign pal_g = s1_pal[2*CW-1:CW];
  assign pal_b = s1_pal[CW-1:0];
  assign bg_b  = scale8(BG_B);
  assign x_cw  = scale8({1'b0, s1_xcoarse});

  // Stage 2 colour select; bubbles produce black.
  always_comb begin
    nxt_r = '0;
    nxt_g = '0;
    nxt_b = '0;
    if (s1_valid) begin
      if (s1_play && s1_flash && flash_phase) begin
        nxt_r = FULL;
        nxt_g = FULL;
        nxt_b = FULL;
      end else if (s1_play) begin
        nxt_r = pal_r;
        nxt_g = pal_g;
        nxt_b = pal_b;
`ifdef GHOST_SHADE_EN
        if (s1_ghost && !s1_flash) begin
          nxt_r = pal_r >> 1;
          nxt_g = pal_g >> 1;
          nxt_b = pal_b >> 1;
        end
`endif
      end else if (s1_ball) begin
        nxt_r = FULL;
      end else begin
        nxt_r = scale8(BG_R);
        nxt_b = (bg_b > x_cw) ? (bg_b - x_cw) : '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      VGA_R         <= nxt_r;
      VGA_G         <= nxt_g;
      VGA_B         <= nxt_b;
    end
  end

  // Row coordinate and fine X bits carry no colour information here.
  logic unused_bits;
`ifdef GHOST_SHADE_EN
  assign unused_bits = ^{DrawY, DrawX[2:0]};
`else
  assign unused_bits = ^{DrawY, DrawX[2:0], ghost};
`endif

endmodule

// File: tb/tb_palette_color_pipeline.sv
// Directed bench for palette_color_pipeline: an 8-bit instance (FLASH_FRAMES=2) plus a 4-bit
// instance for background saturation. Honours GHOST_SHADE_EN when it is defined.
module tb_palette_color_pipeline;

  logic        Clk;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid_in;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        play_area;
  logic        is_ball;
  logic [2:0]  block_type;
  logic        flash_row;
  logic        ghost;
  logic        pal_wr_en;
  logic [2:0]  pal_wr_idx;
  logic [23:0] pal_wr_rgb;
  logic        pix_valid_out;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  logic        pal_wr_en4;
  logic [11:0] pal_wr_rgb4;
  logic        pix_valid_out4;
  logic [3:0]  VGA_R4, VGA_G4, VGA_B4;

  logic [24:0] out8;
  logic [12:0] out4;

  int total = 0;
  int bad   = 0;
  int pulses;
  logic [23:0] palExp [8];

  assign out8 = {pix_valid_out, VGA_R, VGA_G, VGA_B};
  assign out4 = {pix_valid_out4, VGA_R4, VGA_G4, VGA_B4};

  palette_color_pipeline #(.CW(8), .IDX_W(3), .FLASH_FRAMES(2), .BG_R(8'h1f), .BG_B(8'h7f)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .play_area(play_area), .is_ball(is_ball),
    .block_type(block_type), .flash_row(flash_row), .ghost(ghost),
    .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb),
    .pix_valid_out(pix_valid_out), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  palette_color_pipeline #(.CW(4), .IDX_W(3), .FLASH_FRAMES(2), .BG_R(8'h1f), .BG_B(8'h10)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .play_area(play_area), .is_ball(is_ball),
    .block_type(block_type), .flash_row(flash_row), .ghost(ghost),
    .pal_wr_en(pal_wr_en4), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb4),
    .pix_valid_out(pix_valid_out4), .VGA_R(VGA_R4), .VGA_G(VGA_G4), .VGA_B(VGA_B4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs; one-shot strobes are dropped after the capturing edge.
  task automatic applyStimulus(input logic v, input logic play, input logic ball, input logic [2:0] bt,
                               input logic fr, input logic gh, input logic [9:0] x);
    pix_valid_in = v;
    play_area    = play;
    is_ball      = ball;
    block_type   = bt;
    flash_row    = fr;
    ghost        = gh;
    DrawX        = x;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    pal_wr_en   = 1'b0;
  endtask

  // Pixel followed by a bubble; output is zero one edge after the pixel and the pixel two edges after.
  task automatic sendPixel(input string tag, input logic play, input logic ball, input logic [2:0] bt,
                           input logic fr, input logic gh, input logic [9:0] x, input logic [24:0] exp8);
    applyStimulus(1'b1, play, ball, bt, fr, gh, x);
    checkOutput({tag, "_lat1"}, 32'(out8), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
    checkOutput(tag, 32'(out8), 32'(exp8));
  endtask

  initial begin
    palExp = '{24'h000000, 24'h00ffff, 24'h0000ff, 24'hffa500,
               24'hffff00, 24'h008000, 24'hff0000, 24'hff00ff};
    Reset_n      = 1'b0;
    frame_start  = 1'b0;
    pix_valid_in = 1'b0;
    DrawX        = '0;
    DrawY        = 10'd5;
    play_area    = 1'b0;
    is_ball      = 1'b0;
    block_type   = '0;
    flash_row    = 1'b0;
    ghost        = 1'b0;
    pal_wr_en    = 1'b0;
    pal_wr_idx   = '0;
    pal_wr_rgb   = '0;
    pal_wr_en4   = 1'b0;
    pal_wr_rgb4  = '0;
    pulses       = 0;

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_out", 32'(out8), 32'h0);
    checkOutput("rst_out4", 32'(out4), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      sendPixel($sformatf("pal%0d", i), 1'b1, 1'b0, 3'(i), 1'b0, 1'b0, 10'd100, {1'b1, palExp[i]});

    sendPixel("ball", 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 10'd200, 25'h1ff0000);
    sendPixel("ball_in_play", 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 10'd200, 25'h1008000);

    sendPixel("bg_x0", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0, 25'h11f007f);
    checkOutput("bg4_x0", 32'(out4), 32'h1101);
    sendPixel("bg_x639", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd639, 25'h11f0030);
    checkOutput("bg4_x639_sat", 32'(out4), 32'h1100);
    sendPixel("bg_x1023", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd1023, 25'h11f0000);

    pal_wr_en  = 1'b1;
    pal_wr_idx = 3'd6;
    pal_wr_rgb = 24'h123456;
    sendPixel("wr_old", 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 10'd0, 25'h1ff0000);
    sendPixel("wr_new", 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 10'd0, 25'h1123456);

`ifdef GHOST_SHADE_EN
    sendPixel("ghost", 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 10'd0, 25'h17f7f00);
`else
    sendPixel("ghost", 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 10'd0, 25'h1ffff00);
`endif

    // Phase toggles on every second frame_start with FLASH_FRAMES=2.
    for (int f = 0; f < 6; f++) begin
      if (((pulses / 2) % 2) == 1) begin
        sendPixel($sformatf("flash%0d", f), 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h1ffffff);
        sendPixel($sformatf("flash_ghost%0d", f), 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 10'd0, 25'h1ffffff);
        sendPixel($sformatf("noflash_row%0d", f), 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 10'd0, 25'h10000ff);
      end else begin
        sendPixel($sformatf("flash%0d", f), 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h10000ff);
      end
      frame_start = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
      pulses++;
    end

    frame_start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
    pulses++;
    sendPixel("flash_pre_toggle", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h1ffffff);
    frame_start = 1'b1;
    pulses++;
    sendPixel("flash_coincide", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h10000ff);

    repeat (2) begin
      frame_start = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
      pulses++;
    end
    sendPixel("flash_before_rst", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h1ffffff);

    applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 10'd0);
    #2;
    Reset_n      = 1'b0;
    pix_valid_in = 1'b0;
    #1;
    checkOutput("midrst_async", 32'(out8), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
    checkOutput("midrst_drop1", 32'(out8), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 10'd0);
    checkOutput("midrst_drop2", 32'(out8), 32'h0);
    sendPixel("rst_pal3", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 10'd0, 25'h1ffa500);
    sendPixel("rst_pal6", 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 10'd0, 25'h1ff0000);
    sendPixel("rst_phase", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 10'd0, 25'h10000ff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
